// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue-side sequencer: op codes,
// sequencer states, instruction field layout and default sizes.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int INSTR_W  = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_EN  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              imm_en;
    logic [2:0]        imm3;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.op     = raw[OP_MSB:OP_LSB];
    d.rd     = raw[RD_MSB:RD_LSB];
    d.rs1    = raw[RS1_MSB:RS1_LSB];
    d.rs2    = raw[RS2_MSB:RS2_LSB];
    d.imm_en = raw[IMM_EN];
    d.imm3   = raw[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction issue / completion bus between an instruction source (master)
// and the sequencer (slave).
interface alu_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic               done;
  logic [REG_AW-1:0]  wb_addr;
  logic [WIDTH-1:0]   wb_data;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two operand read ports and a debug read port,
// all combinational, one synchronous write port; r0 is hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NREGS = NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  logic [WIDTH-1:0] mem [NREGS];

  // NOTE: the array is reset entry by entry because every register must read
  // 0 after reset; this keeps it in flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the combinational ALU: accepts one instruction,
// reads operands, drives the ALU, captures and writes back the result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NREGS = NUM_REGS
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_if.slave     bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_sel,
  input  logic [WIDTH-1:0]   alu_result,
  output logic [2:0]         flags,
  input  logic               cfg_we,
  input  logic [REG_AW-1:0]  cfg_addr,
  input  logic [WIDTH-1:0]   cfg_wdata,
  output logic               cfg_ready,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [WIDTH-1:0]   dbg_data
);

  state_t            state, state_next;
  instr_t            instr_q;
  logic              accept;
  logic              done_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic [WIDTH-1:0]  rs1_data, rs2_data, op_b;
  logic              wb_we, cfg_accept;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.instr_valid) state_next = ST_READ;
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.instr_ready = (state == ST_IDLE);
  assign cfg_ready       = (state == ST_IDLE);
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (!rst_n)      instr_q <= '0;
    else if (accept) instr_q <= decode(bus.instr);
  end

  assign op_b = instr_q.imm_en ? {{(WIDTH-3){1'b0}}, instr_q.imm3} : rs2_data;

  // Loaded on leaving READ, so the ALU inputs change exactly at the start of
  // EXEC and hold their values through WB and IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (state == ST_READ) begin
      alu_a   <= rs1_data;
      alu_b   <= op_b;
      alu_sel <= instr_q.op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      done_q <= (state == ST_EXEC);
      if (state == ST_EXEC) begin
        wb_addr_q <= instr_q.rd;
        wb_data_q <= alu_result;
      end
    end
  end

  assign bus.done    = done_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

  // Compare result encoding: 0 = equal, 1 = a > b, 2 = a < b.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= '0;
    end else if ((state == ST_WB) && (instr_q.op == OP_CMP)) begin
      flags <= {wb_data_q == WIDTH'(2), wb_data_q == WIDTH'(1), wb_data_q == WIDTH'(0)};
    end
  end

  assign wb_we      = (state == ST_WB);
  assign cfg_accept = cfg_we && cfg_ready;
  assign rf_we      = wb_we || cfg_accept;
  assign rf_waddr   = wb_we ? instr_q.rd : cfg_addr;
  assign rf_wdata   = wb_we ? wb_data_q  : cfg_wdata;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .raddr1   (instr_q.rs1),
    .rdata1   (rs1_data),
    .raddr2   (instr_q.rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  a_done_only_in_wb : assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> (state == ST_WB));

  a_no_cfg_outside_idle : assert property (@(posedge clk) disable iff (!rst_n)
    wb_we |-> !cfg_accept);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; the ALU is modelled here.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       alu_a, alu_b, alu_result, cfg_wdata, dbg_data;
  logic [2:0]        alu_sel, flags, cfg_addr, dbg_addr;
  logic              cfg_we, cfg_ready;
  int                checks = 0;
  int                errors = 0;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .flags      (flags),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_ready  (cfg_ready),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] sel);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << b[3:0];
      3'b110:  return a >> b[3:0];
      default: return (a > b) ? 16'd1 : ((a < b) ? 16'd2 : 16'd0);
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_a, alu_b, alu_sel);

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic imm_en, input logic [2:0] imm3);
    return {op, rd, rs1, rs2, imm_en, imm3};
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic read_dbg(input logic [2:0] addr, output logic [15:0] data);
    dbg_addr = addr;
    #1;
    data = dbg_data;
  endtask

  task automatic accept_instr(input logic [15:0] raw);
    int w = 0;
    while (!bus.instr_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    if (!bus.instr_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: instr_ready=%b required 1", bus.instr_ready);
    end
    bus.instr = raw; bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [2:0] addr, output logic [15:0] data);
    lat = -1; addr = '0; data = '0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done) begin
        lat = k; addr = bus.wb_addr; data = bus.wb_data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input string name, input logic [15:0] raw,
                       input logic [2:0] exp_addr, input logic [15:0] exp_data);
    int lat; logic [2:0] a; logic [15:0] d;
    accept_instr(raw);
    wait_done(lat, a, d);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL %s_latency: got %0d required 3", name, lat);
    end
    checks++;
    if (a !== exp_addr || d !== exp_data) begin
      errors++;
      $display("FAIL %s_wb: got addr=%0d data=%h required addr=%0d data=%h",
               name, a, d, exp_addr, exp_data);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; dbg_addr = '0;
    bus.instr_valid = 1'b0; bus.instr = '0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    checks++;
    if ({bus.instr_ready, cfg_ready, bus.done} !== 3'b110) begin
      errors++; $display("FAIL reset_ctrl: ready/cfg_ready/done=%b required 110",
                         {bus.instr_ready, cfg_ready, bus.done});
    end
    checks++;
    if (bus.wb_addr !== 3'd0 || bus.wb_data !== 16'h0 || flags !== 3'b000) begin
      errors++; $display("FAIL reset_wb: wb_addr=%0d wb_data=%h flags=%b required 0",
                         bus.wb_addr, bus.wb_data, flags);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_sel !== 3'b000) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h sel=%b required 0", alu_a, alu_b, alu_sel);
    end
    for (int r = 0; r < 8; r++) begin
      read_dbg(3'(r), d);
      checks++;
      if (d !== 16'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h required 0000", r, d);
      end
    end
  endtask

  task automatic test_add();
    logic [15:0] d;
    cfg_write(3'd1, 16'h0005);
    cfg_write(3'd2, 16'h0003);
    issue("add", enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0), 3'd3, 16'h0008);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse: done=%b after writeback required 0", bus.done);
    end
    read_dbg(3'd3, d);
    checks++;
    if (d !== 16'h0008) begin
      errors++; $display("FAIL add_dbg: r3=%h required 0008", d);
    end
  endtask

  task automatic test_sub_shl();
    cfg_write(3'd1, 16'h0001);
    issue("sub_wrap", enc(OP_SUB, 3'd4, 3'd0, 3'd1, 1'b0, 3'd0), 3'd4, 16'hFFFF);
    issue("shl_imm",  enc(OP_SHL, 3'd5, 3'd1, 3'd0, 1'b1, 3'd7), 3'd5, 16'h0080);
  endtask

  task automatic test_cmp();
    cfg_write(3'd1, 16'h0009);
    cfg_write(3'd2, 16'h0004);
    issue("cmp_gt", enc(OP_CMP, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0), 3'd6, 16'h0001);
    checks++;
    if (flags !== 3'b010) begin errors++; $display("FAIL cmp_gt_flags: got %b required 010", flags); end
    issue("cmp_lt", enc(OP_CMP, 3'd6, 3'd2, 3'd1, 1'b0, 3'd0), 3'd6, 16'h0002);
    checks++;
    if (flags !== 3'b100) begin errors++; $display("FAIL cmp_lt_flags: got %b required 100", flags); end
    issue("cmp_eq", enc(OP_CMP, 3'd6, 3'd1, 3'd1, 1'b0, 3'd0), 3'd6, 16'h0000);
    checks++;
    if (flags !== 3'b001) begin errors++; $display("FAIL cmp_eq_flags: got %b required 001", flags); end
    issue("add_keep", enc(OP_ADD, 3'd7, 3'd1, 3'd2, 1'b0, 3'd0), 3'd7, 16'h000D);
    checks++;
    if (flags !== 3'b001) begin errors++; $display("FAIL flags_hold: got %b required 001", flags); end
  endtask

  task automatic test_r0();
    logic [15:0] d;
    issue("add_r0", enc(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, 3'd0), 3'd0, 16'h000D);
    read_dbg(3'd0, d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL r0_wb_dropped: r0=%h required 0000", d); end
    cfg_write(3'd0, 16'h1234);
    read_dbg(3'd0, d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL r0_cfg_dropped: r0=%h required 0000", d); end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int ndone = 0;
    int n, w;
    logic [15:0] d;
    bus.instr = enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0);
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (bus.instr_ready) accepts.push_back(c);
      if (bus.done) ndone++;
      if (accepts.size() > 0 && c == accepts[0] + 2) begin
        checks++;
        if (cfg_ready !== 1'b0) begin
          errors++; $display("FAIL exec_cfg_ready: got %b required 0", cfg_ready);
        end
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 16'hBEEF;
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0; cfg_we = 1'b0;
    n = accepts.size();
    checks++;
    if (n !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d required 4", n); end
    for (int i = 0; i + 1 < n; i++) begin
      checks++;
      if (accepts[i+1] - accepts[i] !== 4) begin
        errors++; $display("FAIL b2b_spacing%0d: got %0d required 4", i, accepts[i+1] - accepts[i]);
      end
    end
    checks++;
    if (ndone !== 3) begin errors++; $display("FAIL b2b_dones: got %0d required 3", ndone); end
    w = 0;
    while (!bus.instr_ready && w < 10) begin @(posedge clk); #1; w++; end
    read_dbg(3'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL exec_cfg_ignored: r2=%h required 0004", d); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [2:0] a; logic [15:0] d;
    accept_instr(enc(OP_ADD, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0));
    @(posedge clk); #1;
    checks++;
    if (alu_a !== 16'h0009 || alu_b !== 16'h0004) begin
      errors++; $display("FAIL mid_exec_operands: a=%h b=%h required 0009 0004", alu_a, alu_b);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.instr_ready, cfg_ready, bus.done} !== 3'b110 || flags !== 3'b000) begin
      errors++; $display("FAIL mid_reset_ctrl: ready/cfg_ready/done=%b flags=%b required 110 000",
                         {bus.instr_ready, cfg_ready, bus.done}, flags);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_sel !== 3'b0 ||
        bus.wb_addr !== 3'd0 || bus.wb_data !== 16'h0) begin
      errors++; $display("FAIL mid_reset_out: a=%h b=%h sel=%b wb_addr=%0d wb_data=%h required 0",
                         alu_a, alu_b, alu_sel, bus.wb_addr, bus.wb_data);
    end
    rst_n = 1'b1;
    bus.instr = enc(OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 3'd5);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset_accept: instr_ready=%b required 0 (in READ)", bus.instr_ready);
    end
    wait_done(lat, a, d);
    checks++;
    if (lat !== 3 || a !== 3'd3 || d !== 16'h0005) begin
      errors++; $display("FAIL post_reset_wb: lat=%0d addr=%0d data=%h required 3 3 0005", lat, a, d);
    end
    read_dbg(3'd4, d);
    checks++;
    if (d !== 16'h0) begin errors++; $display("FAIL abandoned_wb: r4=%h required 0000", d); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shl();
    test_cmp();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue-side controller for the 16-bit combinational ALU. Accepts one encoded instruction at a time over a valid/ready handshake, reads two operands from an internal 8×16 register file, drives the ALU operand and select inputs, captures the ALU result, writes it back, and reports completion. It sits between instruction source and ALU, supplying every `a`, `b`, `sel` the ALU sees.

## Interface
- `WIDTH`, 16: data and register width; must match the ALU.
- `NREGS`, 8: register count; address width is log2(NREGS) = 3.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction.
- `instr`  in  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] imm_en, [2:0] imm3.
- `alu_a`  out  WIDTH  operand A to ALU.
- `alu_b`  out  WIDTH  operand B to ALU.
- `alu_sel`  out  3  op select to ALU.
- `alu_result`  in  WIDTH  ALU output.
- `done`  out  1  one-cycle pulse: writeback occurred.
- `wb_addr`  out  3  register written; valid while `done`.
- `wb_data`  out  WIDTH  value written; valid while `done`.
- `flags`  out  3  {lt, gt, eq} from last compare op.
- `cfg_we`  in  1  host register write.
- `cfg_addr`  in  3  host write address.
- `cfg_wdata`  in  WIDTH  host write data.
- `cfg_ready`  out  1  host write will be honored this cycle.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  WIDTH  combinational read of `dbg_addr`.

## Operation
- FSM: IDLE → READ → EXEC → WB → IDLE.
- IDLE: `instr_ready`=1, `cfg_ready`=1. On `instr_valid`&&`instr_ready`, latch `instr` and go to READ.
- READ: opA ← reg[rs1]; opB ← imm_en ? zero-extended imm3 : reg[rs2]; latched into operand registers.
- EXEC: `alu_a`/`alu_b`/`alu_sel` driven from registered operands and op; ALU settles combinationally.
- WB: reg[rd] ← `alu_result`; `done`=1; `wb_addr`=rd; `wb_data`=`alu_result`. If op=3'b111, flags ← {result==2, result==1, result==0}; other ops leave flags unchanged.
- r0 always reads 0; writes to r0 (writeback or cfg) are dropped, but `done` still pulses with `wb_addr`=0 and `wb_data`=`alu_result`.
- Op codes pass through unchanged: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 cmp. Add/sub wrap modulo 2^16; no carry captured.
- `cfg_we` honored only when `cfg_ready`; otherwise ignored.
- Same-cycle cfg write and instruction accept in IDLE: both take effect; READ next cycle sees the new value.
- Outside EXEC, `alu_a`, `alu_b`, `alu_sel` hold their last values. They are 0 after reset.

## Timing
- Accept in cycle T; READ T+1; EXEC T+2; `done` T+3; `instr_ready` high again T+4.
- Throughput: one instruction per 4 cycles. No pipelining or back-to-back overlap.
- Reset values: state IDLE, `instr_ready`=1, `cfg_ready`=1, `done`=0, `wb_addr`=0, `wb_data`=0, `flags`=0, `alu_a`/`alu_b`=0, `alu_sel`=0, all registers 0.
- Reset mid-instruction: the in-flight instruction is abandoned with no writeback and no `done`. The next cycle is IDLE.
- `instr_valid` outside IDLE is ignored. The source must hold `instr` until accepted.

## Structure
- Shared package `alu_pkg`: op-code constants (`OP_ADD` … `OP_CMP`), FSM state enum, instruction field positions, `WIDTH` default.
- The ALU reuses the same op constants from `alu_pkg`.
- Sub-module `alu_regfile`: NREGS×WIDTH, two combinational read ports plus a debug read port, one synchronous write port, r0 hardwired zero. The sequencer muxes writeback vs cfg into its write port.
- ALU is instantiated at the level above, not inside this block.

## Test plan
- Reset, then cfg r1=0x0005, r2=0x0003. Issue add r3,r1,r2 → `done` exactly 3 cycles after accept, `wb_addr`=3, `wb_data`=0x0008, `dbg_data`(3)=0x0008.
- r1=0x0001. Issue sub r4,r0,r1 → `wb_data`=0xFFFF (wrap). Then shl r5,r1,imm 7 → `wb_data`=0x0080.
- r1=0x0009, r2=0x0004. Issue cmp r6,r1,r2 → `wb_data`=0x0001, flags=3'b010. Swap operands → `wb_data`=0x0002, flags=3'b100. Equal operands → `wb_data`=0x0000, flags=3'b001.
- Issue add r0,r1,r2 → `done` pulses, r0 still reads 0. Cfg write to r0 → no effect.
- Hold `instr_valid` high continuously → accepts are exactly 4 cycles apart. A cfg write attempted during EXEC sees `cfg_ready`=0 and the register is unchanged.
- Assert `rst_n`=0 during EXEC → no `done`. All outputs return to reset values the next cycle. A new instruction is accepted the cycle after reset releases.
